// File: rtl/serial_subtractor_if.sv
// Handshake bundle for the bit-serial subtractor: operand request side and result side.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB-first,
// with a registered borrow, and holds the result until the consumer takes it.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, diff_q, res_full;
    logic             br, br_nxt, d, bout_q, zero_q, last, accept;
    logic [CW-1:0]    cnt;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last     = (cnt == CW'(WIDTH - 1));
    assign d        = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt   = (~a_sr[0] & b_sr[0]) | (b_sr[0] & br) | (~a_sr[0] & br);
    assign res_full = {d, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result registers move only on completion, so they also hold through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_sr <= bus.a;
                    b_sr <= bus.b;
                    br   <= bus.bin;
                    cnt  <= '0;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_full;
                    br     <= br_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff_q <= res_full;
                        bout_q <= br_nxt;
                        zero_q <= (res_full == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop on handshake.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [9:0] q8[$];
    logic [5:0] q4[$];

    serial_subtractor_if #(.WIDTH(8)) b8 ();
    serial_subtractor_if #(.WIDTH(4)) b4 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL res8_unexpected: got diff 0x%0h expected no result", b8.diff);
            end else begin
                e = q8.pop_front();
                chk("diff8", 32'(b8.diff), 32'(e[9:2]));
                chk("bout8", 32'(b8.bout), 32'(e[1]));
                chk("zero8", 32'(b8.zero), 32'(e[0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (rst_n && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL res4_unexpected: got diff 0x%0h expected no result", b4.diff);
            end else begin
                e = q4.pop_front();
                chk("diff4", 32'(b4.diff), 32'(e[5:2]));
                chk("bout4", 32'(b4.bout), 32'(e[1]));
                chk("zero4", 32'(b4.zero), 32'(e[0]));
            end
        end
    end

    // Drives one operand set, waits for acceptance, pushes the arithmetic expectation.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input bit keep, output int acc_cyc);
        logic [8:0] full;
        int t = 0;
        b8.in_valid = 1'b1; b8.a = a; b8.b = b; b8.bin = bin;
        while (!b8.in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!b8.in_ready) begin
            checks++; errors++;
            $display("FAIL accept8_timeout: got in_ready 0 expected 1");
        end
        full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        q8.push_back({full[7:0], full[8], full[7:0] == 8'd0});
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!keep) b8.in_valid = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [4:0] full;
        int t = 0;
        b4.in_valid = 1'b1; b4.a = a; b4.b = b; b4.bin = bin;
        while (!b4.in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!b4.in_ready) begin
            checks++; errors++;
            $display("FAIL accept4_timeout: got in_ready 0 expected 1");
        end
        full = {1'b0, a} - {1'b0, b} - {4'd0, bin};
        q4.push_back({full[3:0], full[4], full[3:0] == 4'd0});
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
    endtask

    initial begin
        int acc, prev, t;
        b8.in_valid = 0; b8.a = 0; b8.b = 0; b8.bin = 0; b8.out_ready = 1;
        b4.in_valid = 0; b4.a = 0; b4.b = 0; b4.bin = 0; b4.out_ready = 1;

        #12;
        chk("rst_in_ready", 32'(b8.in_ready), 1);
        chk("rst_out_valid", 32'(b8.out_valid), 0);
        chk("rst_diff", 32'(b8.diff), 0);
        chk("rst_bout", 32'(b8.bout), 0);
        chk("rst_zero", 32'(b8.zero), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // First op after reset, held in DONE by backpressure, with ignored operands.
        b8.out_ready = 1'b0;
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, acc);
        b8.in_valid = 1'b1; b8.a = 8'hFF; b8.b = 8'h01; b8.bin = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk("lat_out_valid", 32'(b8.out_valid), 32'(k == 8));
            chk("busy_in_ready", 32'(b8.in_ready), 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(b8.out_valid), 1);
            chk("bp_in_ready", 32'(b8.in_ready), 0);
            chk("bp_diff", 32'(b8.diff), 32'h1E);
            chk("bp_bout", 32'(b8.bout), 0);
            chk("bp_zero", 32'(b8.zero), 0);
        end
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_in_ready", 32'(b8.in_ready), 1);
        chk("hold_diff_idle", 32'(b8.diff), 32'h1E);

        op8(8'hFF, 8'h01, 1'b0, 1'b0, acc);
        op8(8'h00, 8'h00, 1'b1, 1'b0, acc);
        op8(8'h10, 8'h20, 1'b0, 1'b0, acc);
        op8(8'h77, 8'h77, 1'b0, 1'b0, acc);

        // Abort during the third SHIFT cycle; reset must act without a clock edge.
        op8(8'hAA, 8'h55, 1'b0, 1'b0, acc);
        void'(q8.pop_back());
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(b8.out_valid), 0);
        chk("midrst_in_ready", 32'(b8.in_ready), 1);
        chk("midrst_diff", 32'(b8.diff), 0);
        #1; rst_n = 1'b1;
        op8(8'h01, 8'h02, 1'b0, 1'b0, acc);

        // Streaming with in_valid held high.
        op8(8'h80, 8'h01, 1'b0, 1'b1, prev);
        op8(8'h03, 8'h04, 1'b1, 1'b1, acc);
        chk("stream_spacing", 32'(acc - prev), 10); prev = acc;
        op8(8'hC8, 8'h64, 1'b1, 1'b1, acc);
        chk("stream_spacing", 32'(acc - prev), 10); prev = acc;
        op8(8'h00, 8'hFF, 1'b0, 1'b0, acc);
        chk("stream_spacing", 32'(acc - prev), 10);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    op4(4'(x), 4'(y), 1'(c));

        t = 0;
        while ((q8.size() != 0 || q4.size() != 0) && t < 200) begin @(posedge clk); t++; end
        chk("drain_q8", 32'(q8.size()), 0);
        chk("drain_q4", 32'(q4.size()), 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; the single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set a/b/bin is valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  registered difference.
REQ-012 bout  output  1  registered borrow-out.
REQ-013 zero  output  1  registered flag, high when diff == 0.

Function
REQ-014 The block SHALL compute diff = (a - b - bin) mod 2^WIDTH, LSB-first, one bit per clock, through a single full-subtractor bit cell plus a registered borrow.
REQ-015 The bit cell SHALL produce d = ai ^ bi ^ br and br_next = (~ai & bi) | (bi & br) | (~ai & br).
REQ-016 After the last bit, bout SHALL equal the final br_next; bout = 1 iff a < b + bin (unsigned).
REQ-017 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-018 IDLE: in_ready = 1 and out_valid = 0.
 - On in_valid & in_ready: capture a and b into the shift registers, load br with bin, clear the bit counter, go to SHIFT.
REQ-019 SHIFT: in_ready = 0 and out_valid = 0.
 - Each cycle: process bit 0 of the operand shift registers, shift both operands right, shift d into the MSB of the partial-result register, update br, increment the counter.
 - After exactly WIDTH SHIFT cycles: load diff, bout and zero from the completed result, go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-021 DONE: out_valid = 1 and in_ready = 0.
 - diff, bout and zero stay stable while out_valid & ~out_ready, for any number of cycles.
 - On out_ready: go to IDLE.
REQ-022 in_ready SHALL be asserted only in IDLE; there is no overlap between operations.
 - The minimum accept-to-accept spacing is WIDTH+2 cycles.
 - in_valid held high continuously SHALL give back-to-back operations with exactly one IDLE cycle between them.
REQ-023 in_valid, a, b and bin SHALL be ignored in SHIFT and DONE. Operand changes after the accepting edge SHALL NOT affect the result.
REQ-024 diff, bout and zero SHALL change only on the SHIFT-to-DONE transition and SHALL hold their values through IDLE until the next completion.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.
REQ-026 out_ready asserted while out_valid = 0 SHALL have no effect.

Reset
REQ-027 While rst_n = 0, the block SHALL immediately, without waiting for clk, force:
 - state to IDLE;
 - in_ready = 1 and out_valid = 0;
 - diff = 0, bout = 0 and zero = 0;
 - shift registers, br and counter to 0.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation with no result delivered.
REQ-029 The first operation after reset release SHALL be accepted on the first clk edge with in_valid = 1 and complete correctly.

Verification (WIDTH = 8 unless stated)
REQ-030 a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0, zero=0; out_valid rises exactly 8 edges after the accepting edge and in_ready stays 0 until out_ready.
REQ-031 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, zero=0.
 - a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1.
 - a=0x77, b=0x77, bin=0 -> diff=0x00, bout=0, zero=1.
REQ-032 Backpressure: with out_ready held 0 for 5 cycles in DONE:
 - out_valid stays 1 and diff/bout/zero are unchanged;
 - in_valid with new operands during SHIFT and DONE is not accepted;
 - after the out_ready handshake, the next accepted operation yields its own correct result.
REQ-033 Reset mid-operation: rst_n pulsed low during the 3rd SHIFT cycle -> out_valid=0, in_ready=1 and diff=0x00 immediately. A following a=0x01, b=0x02, bin=0 -> diff=0xFF, bout=1.
REQ-034 Streaming: in_valid held 1 with 4 queued operand sets -> 4 results in order, each spaced WIDTH+2 cycles, all matching the REQ-014/REQ-016 model.
REQ-035 WIDTH=4, exhaustive: all 512 (a, b, bin) combinations -> diff, bout and zero match the arithmetic model of REQ-014/REQ-016 with no mismatch.
